// File: rtl/mbox_req_arb.sv
// ---------------------------------------------------------------------------
// MbOxReqArb -- mbox_req_arb
//
// Purpose:
//   Collects memory requests from N_CHAN EBOX-side requesters (microcode VMA
//   path, PI, page refill, diagnostics), grants them round-robin into a small
//   request FIFO, and feeds the single MBOX request port one request at a
//   time.  Each issued request waits for completion, a cache retry or a
//   timeout.  The response is routed back to the channel that made the
//   request.
//
// Ports:
//   clk            system clock
//   CROBAR         synchronous active-high reset
//   reqValid       per-channel request present
//   reqReady       per-channel request accepted this cycle
//   reqWrite       per-channel write (1) / read (0)
//   reqAdr         packed per-channel addresses, channel 0 in the LSBs
//   reqData        packed per-channel write data, channel 0 in the LSBs
//   respValid      one-cycle response pulse to the owning channel
//   respData       read data (0 for writes and error responses)
//   respErr        qualifies respValid: timeout or retry exhaustion
//   EBOX_REQ       one-cycle request strobe to the MBOX
//   EBOX_VMA       request address (FIFO head)
//   eboxWrite      write qualifier (FIFO head)
//   cacheDataWrite write data (FIFO head)
//   mboxRespIn     MBOX completion
//   cshEBOXRetry   cache asks for the request to be reissued
//   cacheDataRead  read data, valid with mboxRespIn
//   nxmTimeout     one-cycle pulse when a request times out
//   busy           FIFO non-empty or sequencer not idle
// ---------------------------------------------------------------------------
module mbox_req_arb #(
    parameter int N_CHAN    = 4,
    parameter int ADR_W     = 23,
    parameter int DATA_W    = 36,
    parameter int QDEPTH    = 4,
    parameter int TIMEOUT   = 1023,
    parameter int MAX_RETRY = 7
) (
    input  logic                       clk,
    input  logic                       CROBAR,
    input  logic [N_CHAN-1:0]          reqValid,
    output logic [N_CHAN-1:0]          reqReady,
    input  logic [N_CHAN-1:0]          reqWrite,
    input  logic [N_CHAN*ADR_W-1:0]    reqAdr,
    input  logic [N_CHAN*DATA_W-1:0]   reqData,
    output logic [N_CHAN-1:0]          respValid,
    output logic [DATA_W-1:0]          respData,
    output logic                       respErr,
    output logic                       EBOX_REQ,
    output logic [ADR_W-1:0]           EBOX_VMA,
    output logic                       eboxWrite,
    output logic [DATA_W-1:0]          cacheDataWrite,
    input  logic                       mboxRespIn,
    input  logic                       cshEBOXRetry,
    input  logic [DATA_W-1:0]          cacheDataRead,
    output logic                       nxmTimeout,
    output logic                       busy
);

    localparam int CHAN_W  = $clog2(N_CHAN);
    localparam int PTR_W   = $clog2(QDEPTH);
    localparam int CNT_W   = $clog2(QDEPTH + 1);
    localparam int TIMER_W = $clog2(TIMEOUT + 1);
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // Unpacked per-channel views of the packed request buses.
    logic [ADR_W-1:0]  chanAdr  [N_CHAN];
    logic [DATA_W-1:0] chanData [N_CHAN];

    for (genvar g = 0; g < N_CHAN; g++) begin : gUnpack
        assign chanAdr[g]  = reqAdr[g*ADR_W +: ADR_W];
        assign chanData[g] = reqData[g*DATA_W +: DATA_W];
    end

    // Request FIFO storage and bookkeeping.
    logic [CHAN_W-1:0] fifoChan  [QDEPTH];
    logic              fifoWrite [QDEPTH];
    logic [ADR_W-1:0]  fifoAdr   [QDEPTH];
    logic [DATA_W-1:0] fifoData  [QDEPTH];

    logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CHAN_W-1:0]  rrPtr_q, rrPtr_d;
    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [N_CHAN-1:0]  respValid_q, respValid_d;
    logic [DATA_W-1:0]  respData_q, respData_d;
    logic               respErr_q, respErr_d;
    logic               nxm_q, nxm_d;

    logic               fifoFull;
    logic               fifoEmpty;
    logic               grantValid;
    logic [CHAN_W-1:0]  grantIdx;
    logic [CHAN_W:0]    candIdx;
    logic               push;
    logic               pop;
    logic               respFire;
    logic [CHAN_W-1:0]  headChan;
    logic               headWrite;
    logic [N_CHAN-1:0]  headOnehot;

    assign fifoFull  = (count_q == CNT_W'(QDEPTH));
    assign fifoEmpty = (count_q == '0);
    assign headChan  = fifoChan[rdPtr_q];
    assign headWrite = fifoWrite[rdPtr_q];

    // Round-robin search: first valid channel at or after the RR pointer,
    // wrapping at N_CHAN.  Full is judged on the registered count, so a pop
    // in the same cycle never opens a slot early.
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = '0;
        candIdx    = '0;
        for (int k = 0; k < N_CHAN; k++) begin
            candIdx = {1'b0, rrPtr_q} + (CHAN_W+1)'(k);
            if (candIdx >= (CHAN_W+1)'(N_CHAN)) begin
                candIdx = candIdx - (CHAN_W+1)'(N_CHAN);
            end
            if (!grantValid && reqValid[candIdx[CHAN_W-1:0]]) begin
                grantValid = 1'b1;
                grantIdx   = candIdx[CHAN_W-1:0];
            end
        end
        push = grantValid && !fifoFull;
    end

    // One-hot forms of the grant (for reqReady) and of the head owner
    // (for response routing).
    always_comb begin
        reqReady   = '0;
        headOnehot = '0;
        for (int i = 0; i < N_CHAN; i++) begin
            reqReady[i]   = push && (grantIdx == CHAN_W'(i));
            headOnehot[i] = (headChan == CHAN_W'(i));
        end
    end

    // FIFO pointer, occupancy and round-robin pointer next-state.
    always_comb begin
        rdPtr_d = pop  ? rdPtr_q + PTR_W'(1) : rdPtr_q;
        wrPtr_d = push ? wrPtr_q + PTR_W'(1) : wrPtr_q;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
        rrPtr_d = rrPtr_q;
        if (push) begin
            rrPtr_d = (grantIdx == CHAN_W'(N_CHAN - 1)) ? '0 : grantIdx + CHAN_W'(1);
        end
    end

    // Sequencer: completion beats retry beats timeout.  Any terminal event
    // pops the head and schedules a registered response for the next cycle.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        retry_d    = retry_q;
        pop        = 1'b0;
        respFire   = 1'b0;
        respErr_d  = 1'b0;
        respData_d = '0;
        nxm_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifoEmpty) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                timer_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                timer_d = timer_q + TIMER_W'(1);
                if (mboxRespIn) begin
                    pop        = 1'b1;
                    respFire   = 1'b1;
                    respData_d = headWrite ? '0 : cacheDataRead;
                    retry_d    = '0;
                    state_d    = ST_IDLE;
                end else if (cshEBOXRetry) begin
                    if (retry_q == RETRY_W'(MAX_RETRY)) begin
                        pop       = 1'b1;
                        respFire  = 1'b1;
                        respErr_d = 1'b1;
                        retry_d   = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = ST_ISSUE;
                    end
                end else if (timer_q == TIMER_W'(TIMEOUT)) begin
                    pop       = 1'b1;
                    respFire  = 1'b1;
                    respErr_d = 1'b1;
                    nxm_d     = 1'b1;
                    retry_d   = '0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        respValid_d = respFire ? headOnehot : '0;
    end

    // Control and response registers; reset drops any outstanding request
    // without producing a response.
    always_ff @(posedge clk) begin
        if (CROBAR) begin
            rdPtr_q     <= '0;
            wrPtr_q     <= '0;
            count_q     <= '0;
            rrPtr_q     <= '0;
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            retry_q     <= '0;
            respValid_q <= '0;
            respData_q  <= '0;
            respErr_q   <= 1'b0;
            nxm_q       <= 1'b0;
        end else begin
            rdPtr_q     <= rdPtr_d;
            wrPtr_q     <= wrPtr_d;
            count_q     <= count_d;
            rrPtr_q     <= rrPtr_d;
            state_q     <= state_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            respValid_q <= respValid_d;
            respData_q  <= respData_d;
            respErr_q   <= respErr_d;
            nxm_q       <= nxm_d;
        end
    end

    // FIFO payload needs no reset; the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoChan[wrPtr_q]  <= grantIdx;
            fifoWrite[wrPtr_q] <= reqWrite[grantIdx];
            fifoAdr[wrPtr_q]   <= chanAdr[grantIdx];
            fifoData[wrPtr_q]  <= chanData[grantIdx];
        end
    end

    // The head only moves on a pop, which coincides with leaving WAIT, so
    // driving the MBOX port from the head keeps it stable across ISSUE/WAIT.
    assign EBOX_VMA       = fifoEmpty ? '0 : fifoAdr[rdPtr_q];
    assign eboxWrite      = fifoEmpty ? 1'b0 : headWrite;
    assign cacheDataWrite = fifoEmpty ? '0 : fifoData[rdPtr_q];
    assign EBOX_REQ       = (state_q == ST_ISSUE);
    assign respValid      = respValid_q;
    assign respData       = respData_q;
    assign respErr        = respErr_q;
    assign nxmTimeout     = nxm_q;
    assign busy           = !fifoEmpty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_mbox_req_arb.sv
// ---------------------------------------------------------------------------
// TbMboxReqArb -- tb_mbox_req_arb
//
// Purpose:
//   Directed bench for mbox_req_arb with the default parameters: single read,
//   round-robin fill of the FIFO, cache retries, retry exhaustion, timeout,
//   completion/retry priority and reset in the middle of a request.
// ---------------------------------------------------------------------------
module tb_mbox_req_arb;

    localparam int N_CHAN = 4;
    localparam int ADR_W  = 23;
    localparam int DATA_W = 36;

    logic                     clk = 1'b0;
    logic                     CROBAR;
    logic [N_CHAN-1:0]        reqValid;
    logic [N_CHAN-1:0]        reqReady;
    logic [N_CHAN-1:0]        reqWrite;
    logic [N_CHAN*ADR_W-1:0]  reqAdr;
    logic [N_CHAN*DATA_W-1:0] reqData;
    logic [N_CHAN-1:0]        respValid;
    logic [DATA_W-1:0]        respData;
    logic                     respErr;
    logic                     EBOX_REQ;
    logic [ADR_W-1:0]         EBOX_VMA;
    logic                     eboxWrite;
    logic [DATA_W-1:0]        cacheDataWrite;
    logic                     mboxRespIn;
    logic                     cshEBOXRetry;
    logic [DATA_W-1:0]        cacheDataRead;
    logic                     nxmTimeout;
    logic                     busy;

    logic [ADR_W-1:0]  adrArr [N_CHAN];
    logic [DATA_W-1:0] datArr [N_CHAN];

    int nAsserts = 0;
    int nFail    = 0;
    int nWait;

    assign reqAdr  = {adrArr[3], adrArr[2], adrArr[1], adrArr[0]};
    assign reqData = {datArr[3], datArr[2], datArr[1], datArr[0]};

    always #5 clk = ~clk;

    mbox_req_arb dut (
        .clk            (clk),
        .CROBAR         (CROBAR),
        .reqValid       (reqValid),
        .reqReady       (reqReady),
        .reqWrite       (reqWrite),
        .reqAdr         (reqAdr),
        .reqData        (reqData),
        .respValid      (respValid),
        .respData       (respData),
        .respErr        (respErr),
        .EBOX_REQ       (EBOX_REQ),
        .EBOX_VMA       (EBOX_VMA),
        .eboxWrite      (eboxWrite),
        .cacheDataWrite (cacheDataWrite),
        .mboxRespIn     (mboxRespIn),
        .cshEBOXRetry   (cshEBOXRetry),
        .cacheDataRead  (cacheDataRead),
        .nxmTimeout     (nxmTimeout),
        .busy           (busy)
    );

    // Advance the given number of clock edges and settle 2 time units past
    // the last edge, where inputs are changed and outputs are sampled.
    task automatic applyStimulus(input int nCycles);
        repeat (nCycles) @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Step until the request strobe shows, bounded so a stuck sequencer
    // still reaches the summary.
    task automatic waitIssue(input string tag);
        int n;
        n = 0;
        while (EBOX_REQ !== 1'b1 && n < 20) begin
            applyStimulus(1);
            n++;
        end
        checkOutput(tag, 64'(EBOX_REQ), 64'd1);
    endtask

    // Linear sequence of directed steps with hand-computed expectations.
    initial begin
        CROBAR        = 1'b1;
        reqValid      = '0;
        reqWrite      = '0;
        mboxRespIn    = 1'b0;
        cshEBOXRetry  = 1'b0;
        cacheDataRead = '0;
        for (int i = 0; i < N_CHAN; i++) begin
            adrArr[i] = '0;
            datArr[i] = '0;
        end

        // Reset state.
        applyStimulus(3);
        checkOutput("rst_busy",      64'(busy),      64'd0);
        checkOutput("rst_ebox_req",  64'(EBOX_REQ),  64'd0);
        checkOutput("rst_respValid", 64'(respValid), 64'd0);
        checkOutput("rst_nxm",       64'(nxmTimeout), 64'd0);
        checkOutput("rst_vma",       64'(EBOX_VMA),  64'd0);
        checkOutput("rst_reqReady",  64'(reqReady),  64'd0);

        // Single read on channel 2.
        CROBAR    = 1'b0;
        adrArr[2] = 23'h1234;
        reqValid  = 4'b0100;
        #1;
        checkOutput("t1_reqReady", 64'(reqReady), 64'h4);
        applyStimulus(1);
        reqValid = '0;
        checkOutput("t1_req_early", 64'(EBOX_REQ), 64'd0);
        checkOutput("t1_busy",      64'(busy),     64'd1);
        checkOutput("t1_vma",       64'(EBOX_VMA), 64'h1234);
        applyStimulus(1);
        checkOutput("t1_req_latency", 64'(EBOX_REQ), 64'd1);
        applyStimulus(1);
        checkOutput("t1_req_pulse", 64'(EBOX_REQ), 64'd0);
        mboxRespIn    = 1'b1;
        cacheDataRead = 36'o123;
        applyStimulus(1);
        mboxRespIn = 1'b0;
        checkOutput("t1_respValid", 64'(respValid), 64'h4);
        checkOutput("t1_respData",  64'(respData),  64'o123);
        checkOutput("t1_respErr",   64'(respErr),   64'd0);
        checkOutput("t1_busy_done", 64'(busy),      64'd0);
        applyStimulus(1);
        checkOutput("t1_resp_pulse", 64'(respValid), 64'd0);

        // All channels valid continuously: grant order 0,1,2,3 then full.
        CROBAR = 1'b1;
        applyStimulus(1);
        CROBAR = 1'b0;
        for (int i = 0; i < N_CHAN; i++) begin
            adrArr[i] = 23'(32'h100 + i);
        end
        reqWrite  = 4'b0010;
        datArr[1] = 36'h9ABCDEF01;
        reqValid  = 4'hF;
        #1;
        checkOutput("rr_grant0", 64'(reqReady), 64'h1);
        applyStimulus(1);
        checkOutput("rr_grant1", 64'(reqReady), 64'h2);
        applyStimulus(1);
        checkOutput("rr_grant2", 64'(reqReady), 64'h4);
        checkOutput("rr_issue",  64'(EBOX_REQ), 64'd1);
        applyStimulus(1);
        checkOutput("rr_grant3", 64'(reqReady), 64'h8);
        applyStimulus(1);
        checkOutput("rr_full",      64'(reqReady), 64'h0);
        checkOutput("rr_full_busy", 64'(busy),     64'd1);
        mboxRespIn    = 1'b1;
        cacheDataRead = 36'h123456789;
        #1;
        checkOutput("rr_full_pop", 64'(reqReady), 64'h0);
        checkOutput("rr_head_vma", 64'(EBOX_VMA), 64'h100);
        applyStimulus(1);
        mboxRespIn = 1'b0;
        checkOutput("rr_resp0",   64'(respValid), 64'h1);
        checkOutput("rr_data0",   64'(respData),  64'h123456789);
        checkOutput("rr_wrap0",   64'(reqReady),  64'h1);
        applyStimulus(1);
        reqValid = '0;
        checkOutput("rr_head1_vma",   64'(EBOX_VMA),       64'h101);
        checkOutput("rr_head1_write", 64'(eboxWrite),      64'd1);
        checkOutput("rr_head1_data",  64'(cacheDataWrite), 64'h9ABCDEF01);

        // Three retries on the channel 1 write: four strobes, same address.
        waitIssue("retry_req0");
        for (int r = 0; r < 3; r++) begin
            applyStimulus(1);
            cshEBOXRetry = 1'b1;
            applyStimulus(1);
            cshEBOXRetry = 1'b0;
            checkOutput($sformatf("retry_req%0d", r + 1), 64'(EBOX_REQ), 64'd1);
            checkOutput($sformatf("retry_vma%0d", r + 1), 64'(EBOX_VMA), 64'h101);
        end
        applyStimulus(1);
        mboxRespIn    = 1'b1;
        cacheDataRead = 36'hFFF;
        applyStimulus(1);
        mboxRespIn = 1'b0;
        checkOutput("retry_respValid", 64'(respValid), 64'h2);
        checkOutput("retry_respData",  64'(respData),  64'h0);
        checkOutput("retry_respErr",   64'(respErr),   64'd0);

        // Eight consecutive retries on channel 2: forced error response.
        waitIssue("exh_req0");
        checkOutput("exh_vma", 64'(EBOX_VMA), 64'h102);
        for (int r = 0; r < 8; r++) begin
            applyStimulus(1);
            cshEBOXRetry = 1'b1;
            applyStimulus(1);
            cshEBOXRetry = 1'b0;
            if (r < 7) begin
                checkOutput($sformatf("exh_reissue%0d", r + 1), 64'(EBOX_REQ), 64'd1);
            end else begin
                checkOutput("exh_respValid", 64'(respValid),  64'h4);
                checkOutput("exh_respErr",   64'(respErr),    64'd1);
                checkOutput("exh_respData",  64'(respData),   64'h0);
                checkOutput("exh_nxm",       64'(nxmTimeout), 64'd0);
            end
        end

        // Timeout on channel 3: response 1025 cycles after the strobe.
        waitIssue("to_req");
        checkOutput("to_vma", 64'(EBOX_VMA), 64'h103);
        nWait = 0;
        while (nxmTimeout !== 1'b1 && nWait < 1100) begin
            applyStimulus(1);
            nWait++;
        end
        checkOutput("to_latency",  64'(nWait),     64'd1025);
        checkOutput("to_nxm",      64'(nxmTimeout), 64'd1);
        checkOutput("to_respErr",  64'(respErr),   64'd1);
        checkOutput("to_respValid", 64'(respValid), 64'h8);
        applyStimulus(1);
        checkOutput("to_nxm_pulse",  64'(nxmTimeout), 64'd0);
        checkOutput("to_resp_pulse", 64'(respValid),  64'd0);

        // Completion and retry together: completion wins.
        waitIssue("prio_req");
        checkOutput("prio_vma", 64'(EBOX_VMA), 64'h100);
        applyStimulus(1);
        mboxRespIn    = 1'b1;
        cshEBOXRetry  = 1'b1;
        cacheDataRead = 36'h55AA;
        applyStimulus(1);
        mboxRespIn   = 1'b0;
        cshEBOXRetry = 1'b0;
        checkOutput("prio_respValid", 64'(respValid), 64'h1);
        checkOutput("prio_respErr",   64'(respErr),   64'd0);
        checkOutput("prio_respData",  64'(respData),  64'h55AA);
        checkOutput("prio_idle_busy", 64'(busy),      64'd0);

        // Reset while waiting with three requests queued.
        reqValid = 4'b0111;
        applyStimulus(3);
        reqValid = '0;
        checkOutput("crb_busy_before", 64'(busy),     64'd1);
        checkOutput("crb_in_wait",     64'(EBOX_REQ), 64'd0);
        checkOutput("crb_head_vma",    64'(EBOX_VMA), 64'h101);
        CROBAR     = 1'b1;
        mboxRespIn = 1'b1;
        applyStimulus(1);
        CROBAR     = 1'b0;
        mboxRespIn = 1'b0;
        checkOutput("crb_busy",      64'(busy),      64'd0);
        checkOutput("crb_respValid", 64'(respValid), 64'd0);
        checkOutput("crb_ebox_req",  64'(EBOX_REQ),  64'd0);
        mboxRespIn   = 1'b1;
        cshEBOXRetry = 1'b1;
        applyStimulus(1);
        mboxRespIn   = 1'b0;
        cshEBOXRetry = 1'b0;
        checkOutput("late_respValid", 64'(respValid), 64'd0);
        checkOutput("late_respErr",   64'(respErr),   64'd0);
        checkOutput("late_busy",      64'(busy),      64'd0);
        applyStimulus(2);
        checkOutput("late_no_req", 64'(EBOX_REQ), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
